// File: rtl/ctrl_hazard_pkg.sv
// Shared types and constants for the hazard/redirect sequencer.
// PC-select encodings, FSM states and default widths.
package ctrl_hazard_pkg;

  localparam int XLEN_DEF = 32;
  localparam int CNT_W_DEF = 32;

  localparam logic PCSEL_ADD4 = 1'b0;
  localparam logic PCSEL_ALU  = 1'b1;

  typedef enum logic {
    RUN   = 1'b0,
    REDIR = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_lu.sv
// Combinational load-use detect between the load in E and
// the source operands of the instruction in D.
module hazard_lu (
  input  logic       memrd_e_i,
  input  logic [4:0] rd_e_i,
  input  logic [4:0] rs1_d_i,
  input  logic [4:0] rs2_d_i,
  input  logic       rs1_use_d_i,
  input  logic       rs2_use_d_i,
  output logic       lu_o
);

  logic hit1;
  logic hit2;

  assign hit1 = rs1_use_d_i && (rs1_d_i == rd_e_i);
  assign hit2 = rs2_use_d_i && (rs2_d_i == rd_e_i);
  assign lu_o = memrd_e_i && (rd_e_i != 5'd0)
                && (hit1 || hit2);

endmodule

// File: rtl/ctrl_hazard.sv
// Per-stage stall/flush generation and held PC redirect
// request for the 5-stage pipeline.
module ctrl_hazard
  import ctrl_hazard_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pcsel_e_i,
  input  logic [XLEN-1:0]  target_e_i,
  input  logic             memrd_e_i,
  input  logic [4:0]       rd_e_i,
  input  logic [4:0]       rs1_d_i,
  input  logic [4:0]       rs2_d_i,
  input  logic             rs1_use_d_i,
  input  logic             rs2_use_d_i,
  input  logic             imem_ready_i,
  input  logic             dmem_wait_i,
  output logic             stall_f_o,
  output logic             stall_d_o,
  output logic             stall_e_o,
  output logic             stall_m_o,
  output logic             flush_d_o,
  output logic             flush_e_o,
  output logic             redir_o,
  output logic [XLEN-1:0]  redir_pc_o,
  output logic [CNT_W-1:0] redir_cnt_o,
  output logic             busy_o
);

  state_e           state_q, state_d;
  logic [XLEN-1:0]  tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             lu;

  hazard_lu u_lu (
    .memrd_e_i   (memrd_e_i),
    .rd_e_i      (rd_e_i),
    .rs1_d_i     (rs1_d_i),
    .rs2_d_i     (rs2_d_i),
    .rs1_use_d_i (rs1_use_d_i),
    .rs2_use_d_i (rs2_use_d_i),
    .lu_o        (lu)
  );

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    cnt_d      = cnt_q;
    stall_f_o  = 1'b0;
    stall_d_o  = 1'b0;
    stall_e_o  = 1'b0;
    stall_m_o  = 1'b0;
    flush_d_o  = 1'b0;
    flush_e_o  = 1'b0;
    redir_o    = 1'b0;
    redir_pc_o = '0;
    if (rst) begin
      flush_d_o = 1'b1;
      flush_e_o = 1'b1;
    end else if (state_q == REDIR) begin
      // D/E only hold wrong-path work here, so keep flushing
      redir_o    = 1'b1;
      redir_pc_o = tgt_q;
      flush_d_o  = 1'b1;
      flush_e_o  = 1'b1;
      stall_m_o  = dmem_wait_i;
      if (imem_ready_i) begin
        cnt_d   = cnt_q + 1'b1;
        state_d = RUN;
      end
    end else if (dmem_wait_i) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      stall_e_o = 1'b1;
      stall_m_o = 1'b1;
    end else if (pcsel_e_i == PCSEL_ALU) begin
      redir_o    = 1'b1;
      redir_pc_o = target_e_i;
      flush_d_o  = 1'b1;
      flush_e_o  = 1'b1;
      if (imem_ready_i) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        tgt_d   = target_e_i;
        state_d = REDIR;
      end
    end else if (lu) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      flush_e_o = 1'b1;
    end
    busy_d = (state_d == REDIR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      tgt_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign redir_cnt_o = cnt_q;
  assign busy_o      = busy_q;

endmodule
